// File: rtl/norm_pkg.sv
// Shared types for the pipelined lead normaliser: widths, lead-count/exponent typedefs
// and the stage-1 payload carried between the count and shift stages.
package norm_pkg;

  localparam int NORM_DATA_WIDTH  = 32;
  localparam int NORM_COUNT_WIDTH = $clog2(NORM_DATA_WIDTH + 1);
  localparam int NORM_EXP_WIDTH   = 8;

  typedef logic [NORM_DATA_WIDTH-1:0]  norm_data_t;
  typedef logic [NORM_COUNT_WIDTH-1:0] lead_count_t;
  typedef logic [NORM_EXP_WIDTH-1:0]   exp_word_t;

  typedef struct packed {
    norm_data_t  data;
    exp_word_t   exp;
    lead_count_t count;
    logic        degen;
  } s1_payload_t;

endpackage

// File: rtl/norm_barrel_shifter.sv
// Combinational log2(DATA_WIDTH)-level left shifter with zero fill; shift amounts of
// DATA_WIDTH or more produce zero.
module norm_barrel_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [COUNT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  data_out
);

  localparam int LEVELS = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  overflow;

  // One conditional power-of-two shift per shamt bit.
  always_comb begin
    shifted = data_in;
    for (int i = 0; i < LEVELS; i++) begin
      if (shamt[i]) begin
        shifted = shifted << (1 << i);
      end
    end
  end

  generate
    if (COUNT_WIDTH > LEVELS) begin : g_ovf
      assign overflow = |shamt[COUNT_WIDTH-1:LEVELS];
    end else begin : g_no_ovf
      assign overflow = 1'b0;
    end
  endgenerate

  assign data_out = overflow ? '0 : shifted;

endmodule

// File: rtl/pipelined_lead_normalizer.sv
// Two-stage leading-zero/one normaliser with valid/ready on both sides.
// Optional NORM_STATS_EN adds saturating result/degenerate counters.
module pipelined_lead_normalizer
  import norm_pkg::*;
#(
  parameter int DATA_WIDTH  = NORM_DATA_WIDTH,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH + 1),
  parameter int EXP_WIDTH   = NORM_EXP_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [EXP_WIDTH-1:0]   in_exp,
  input  logic                   in_ones,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [EXP_WIDTH-1:0]   out_exp,
  output logic [COUNT_WIDTH-1:0] out_shift,
  output logic                   out_degen,
  output logic                   out_underflow
`ifdef NORM_STATS_EN
  ,
  input  logic                   stat_clear,
  output logic [31:0]            stat_words,
  output logic [31:0]            stat_degen
`endif
);

  localparam int CMP_W = ((EXP_WIDTH > COUNT_WIDTH) ? EXP_WIDTH : COUNT_WIDTH) + 1;

  logic        s1_valid_reg;
  s1_payload_t s1_reg;
  s1_payload_t s1_next;
  logic        s1_adv;
  logic        s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: leading count as an MSB-first priority scan over bits that differ from the mode.
  logic [DATA_WIDTH-1:0] bit_diff;
  lead_count_t           lead_cnt;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_diff
      assign bit_diff[gi] = in_data[gi] ^ in_ones;
    end
  endgenerate

  always_comb begin
    lead_cnt = lead_count_t'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_diff[i]) begin
        lead_cnt = lead_count_t'(DATA_WIDTH - 1 - i);
      end
    end
  end

  always_comb begin
    s1_next.data  = in_data;
    s1_next.exp   = in_exp;
    s1_next.count = lead_cnt;
    s1_next.degen = (lead_cnt == lead_count_t'(DATA_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_reg <= s1_next;
      end
    end
  end

  // Stage 2: shift, exponent adjust with clamp, degenerate override.
  norm_data_t         shifted;
  logic [CMP_W-1:0]   exp_ext;
  logic [CMP_W-1:0]   cnt_ext;
  exp_word_t          exp_diff;
  logic               underflow_next;
  exp_word_t          exp_next;
  norm_data_t         data_next;

  norm_barrel_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_shifter (
    .data_in  (s1_reg.data),
    .shamt    (s1_reg.count),
    .data_out (shifted)
  );

  always_comb begin
    exp_ext        = CMP_W'(s1_reg.exp);
    cnt_ext        = CMP_W'(s1_reg.count);
    exp_diff       = s1_reg.exp - exp_word_t'(s1_reg.count);
    underflow_next = !s1_reg.degen && (cnt_ext > exp_ext);
    exp_next       = (s1_reg.degen || underflow_next) ? '0 : exp_diff;
    data_next      = s1_reg.degen ? s1_reg.data : shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_exp       <= '0;
      out_shift     <= '0;
      out_degen     <= 1'b0;
      out_underflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data      <= data_next;
        out_exp       <= exp_next;
        out_shift     <= s1_reg.count;
        out_degen     <= s1_reg.degen;
        out_underflow <= underflow_next;
      end
    end
  end

`ifdef NORM_STATS_EN
  logic result_fire;
  assign result_fire = out_valid && out_ready;

  // Clear takes priority over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words <= '0;
      stat_degen <= '0;
    end else if (stat_clear) begin
      stat_words <= '0;
      stat_degen <= '0;
    end else if (result_fire) begin
      if (stat_words != '1) begin
        stat_words <= stat_words + 32'd1;
      end
      if (out_degen && (stat_degen != '1)) begin
        stat_degen <= stat_degen + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_lead_normalizer.sv
// Randomised self-checking bench for pipelined_lead_normalizer with a behavioural model.
// Define NORM_STATS_EN to also exercise the statistics counters.
module tb_pipelined_lead_normalizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_exp;
  logic        in_ones;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_exp;
  logic [5:0]  out_shift;
  logic        out_degen;
  logic        out_underflow;
`ifdef NORM_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_words;
  logic [31:0] stat_degen;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  pipelined_lead_normalizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_exp        (in_exp),
    .in_ones       (in_ones),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_exp       (out_exp),
    .out_shift     (out_shift),
    .out_degen     (out_degen),
    .out_underflow (out_underflow)
`ifdef NORM_STATS_EN
    ,
    .stat_clear    (stat_clear),
    .stat_words    (stat_words),
    .stat_degen    (stat_degen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {data, exp, shift, degen, underflow} straight from the normalisation rules.
  function automatic logic [47:0] model(input logic [31:0] d, input logic [7:0] e, input logic o);
    int n = 0;
    logic [31:0] sh;
    while (n < 32 && d[31-n] == o) n++;
    if (n == 32) return {d, 8'd0, 6'd32, 1'b1, 1'b0};
    sh = d << n;
    if (int'(e) >= n) return {sh, 8'(int'(e) - n), 6'(n), 1'b0, 1'b0};
    return {sh, 8'd0, 6'(n), 1'b0, 1'b1};
  endfunction

  function automatic logic [47:0] observed();
    return {out_data, out_exp, out_shift, out_degen, out_underflow};
  endfunction

  task automatic rand_word(output logic [31:0] d, output logic [7:0] e, output logic o);
    int sel = $urandom_range(0, 9);
    o = 1'($urandom_range(0, 1));
    d = $urandom >> $urandom_range(0, 31);
    if (sel == 0) d = 32'd0;
    if (o) d = ~d;
    e = 8'($urandom_range(0, 255));
  endtask

  // Sends one word into an empty pipeline and returns the result plus observed latency.
  task automatic send_one(input logic [31:0] d, input logic [7:0] e, input logic o,
                          output logic [47:0] res, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_exp    = e;
    in_ones   = o;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = observed();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, observed()} !== 49'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h want=0", {out_valid, observed()});
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset released out_valid=%b", out_valid);
  endtask

  task automatic test_directed();
    logic [31:0] dd [9] = '{32'h0000_1000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF,
                            32'hFFF0_0000, 32'h8000_0000, 32'h00FF_0000, 32'h7FFF_FFFF,
                            32'h0000_0003};
    logic [7:0]  ee [9] = '{8'd20, 8'd5, 8'd50, 8'd7, 8'd100, 8'd9, 8'd3, 8'd0, 8'd30};
    logic        oo [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [47:0] res, want;
    int lat;
    for (int i = 0; i < 9; i++) begin
      send_one(dd[i], ee[i], oo[i], res, lat);
      want = model(dd[i], ee[i], oo[i]);
      $display("[TB] directed d=%h e=%0d ones=%b -> %h lat=%0d", dd[i], ee[i], oo[i], res, lat);
      tests_run++;
      if (res !== want) begin
        tests_failed++;
        $display("FAIL directed_%0d got=%h want=%h", i, res, want);
      end
      tests_run++;
      if (lat != 2) begin
        tests_failed++;
        $display("FAIL latency_%0d got=%0d want=2", i, lat);
      end
    end
  endtask

  task automatic test_random_single();
    logic [31:0] d;
    logic [7:0]  e;
    logic        o;
    logic [47:0] res, want;
    int lat;
    for (int i = 0; i < 20; i++) begin
      rand_word(d, e, o);
      send_one(d, e, o, res, lat);
      want = model(d, e, o);
      $display("[TB] random d=%h e=%0d ones=%b -> %h", d, e, o, res);
      tests_run++;
      if (res !== want || lat != 2) begin
        tests_failed++;
        $display("FAIL random_%0d got=%h lat=%0d want=%h lat=2", i, res, lat, want);
      end
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 40;
    logic [31:0] wd [N];
    logic [7:0]  we [N];
    logic        wo [N];
    logic [47:0] expq [$];
    logic [47:0] snap, want;
    logic stalled = 1'b0;
    int n_tx = 0, n_rx = 0;
    for (int i = 0; i < N; i++) rand_word(wd[i], we[i], wo[i]);
    for (int cyc = 0; cyc < 2000 && n_rx < N; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        tests_run++;
        if (!out_valid || observed() !== snap) begin
          tests_failed++;
          $display("FAIL stall_hold got=%b/%h want=1/%h", out_valid, observed(), snap);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (n_tx < N);
      if (n_tx < N) begin
        in_data = wd[n_tx];
        in_exp  = we[n_tx];
        in_ones = wo[n_tx];
      end
      #4;
      stalled = out_valid && !out_ready;
      snap    = observed();
      if (out_valid && out_ready) begin
        want = (expq.size() > 0) ? expq.pop_front() : 48'hx;
        $display("[TB] bp result %0d got=%h", n_rx, observed());
        tests_run++;
        if (observed() !== want) begin
          tests_failed++;
          $display("FAIL bp_result_%0d got=%h want=%h", n_rx, observed(), want);
        end
        n_rx++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(wd[n_tx], we[n_tx], wo[n_tx]));
        n_tx++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (n_rx != N) begin
      tests_failed++;
      $display("FAIL bp_count got=%0d want=%0d", n_rx, N);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_no_dup got=%b want=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    logic [31:0] wd [N];
    logic [7:0]  we [N];
    logic        wo [N];
    logic [47:0] expq [$];
    logic [47:0] want;
    int n_tx = 0, n_rx = 0, first = -1, last = -1, bubbles = 0;
    for (int i = 0; i < N; i++) rand_word(wd[i], we[i], wo[i]);
    for (int cyc = 0; cyc < 200 && n_rx < N; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (n_tx < N);
      if (n_tx < N) begin
        in_data = wd[n_tx];
        in_exp  = we[n_tx];
        in_ones = wo[n_tx];
      end
      #4;
      if (in_valid && !in_ready) bubbles++;
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        want = (expq.size() > 0) ? expq.pop_front() : 48'hx;
        $display("[TB] b2b result %0d got=%h", n_rx, observed());
        tests_run++;
        if (observed() !== want) begin
          tests_failed++;
          $display("FAIL b2b_result_%0d got=%h want=%h", n_rx, observed(), want);
        end
        n_rx++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(wd[n_tx], we[n_tx], wo[n_tx]));
        n_tx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (bubbles != 0 || n_rx != N || (last - first) != N - 1) begin
      tests_failed++;
      $display("FAIL b2b_rate got=rx%0d span%0d stalls%0d want=rx%0d span%0d stalls0",
               n_rx, last - first + 1, bubbles, N, N);
    end
  endtask

  task automatic test_reset_midstream();
    logic ok = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_00F0;
    in_exp    = 8'd40;
    in_ones   = 1'b0;
    @(negedge clk);
    in_data   = 32'h0F00_0000;
    @(negedge clk);
    in_valid  = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_inflight got=%b want=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] mid-stream reset out_valid=%b", out_valid);
    tests_run++;
    if (out_valid !== 1'b0 || observed() !== 48'd0) begin
      tests_failed++;
      $display("FAIL midrst_clear got=%b/%h want=0/0", out_valid, observed());
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL midrst_discard got=valid want=no output");
    end
  endtask

`ifdef NORM_STATS_EN
  task automatic test_stats();
    logic [47:0] res;
    int lat;
    logic [31:0] d;
    logic [7:0]  e;
    logic        o;
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_word(d, e, o);
      if (i == 2 || i == 5 || i == 8) d = o ? 32'hFFFF_FFFF : 32'h0;
      else if (d == (o ? 32'hFFFF_FFFF : 32'h0)) d = d ^ 32'h1;
      send_one(d, e, o, res, lat);
    end
    @(negedge clk);
    $display("[TB] stats words=%0d degen=%0d", stat_words, stat_degen);
    tests_run++;
    if (stat_words !== 32'd10 || stat_degen !== 32'd3) begin
      tests_failed++;
      $display("FAIL stat_counts got=%0d/%0d want=10/3", stat_words, stat_degen);
    end
    // Clear lands in the same cycle the next result is accepted.
    send_one(32'h0, 8'd1, 1'b0, res, lat);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    tests_run++;
    if (stat_words !== 32'd0 || stat_degen !== 32'd0) begin
      tests_failed++;
      $display("FAIL stat_clear got=%0d/%0d want=0/0", stat_words, stat_degen);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_exp    = '0;
    in_ones   = 1'b0;
    out_ready = 1'b0;
`ifdef NORM_STATS_EN
    stat_clear = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random_single();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
`ifdef NORM_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
